func_hdl_stream_shell: RTL and testbench

//  Next-generation wrapper between the AXI read master stream(s) and the AXI write master on the

---
 rtl/func_hdl_pkg.sv | 22 ++
 rtl/func_hdl_sync_fifo.sv | 78 +++++++
 rtl/func_hdl_stream_shell.sv | 175 +++++++++++++++++
 tb/tb_func_hdl_stream_shell.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/func_hdl_pkg.sv
// Shared types and sizing helpers for the stream shell and its output FIFO.
package func_hdl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LP_DEF_FIFO_DEPTH = 16;
  localparam int LP_CREDIT_W       = $clog2(LP_DEF_FIFO_DEPTH + 1);

  // Width able to hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/func_hdl_sync_fifo.sv
// First-word-fall-through FIFO; the head word sits in a register that is
// preloaded from the array one cycle ahead, with bypass for a same-slot write.
module func_hdl_sync_fifo
  import func_hdl_pkg::*;
#(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_DEPTH      = LP_DEF_FIFO_DEPTH,
  parameter int C_LEVEL_W    = LP_CREDIT_W
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    wr_en,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(C_DEPTH);
  localparam logic [C_LEVEL_W-1:0] LEVEL_FULL = C_LEVEL_W'(C_DEPTH);

  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0]           wr_ptr_reg;
  logic [AW-1:0]           rd_ptr_reg;
  logic [AW-1:0]           rd_ptr_next;
  logic [C_LEVEL_W-1:0]    level_reg;
  logic [C_LEVEL_W-1:0]    level_next;
  logic [C_DATA_WIDTH-1:0] rd_data_reg;
  logic                    full_reg;
  logic                    empty_reg;
  logic                    wr_ok;
  logic                    rd_ok;

  assign wr_ok = wr_en && !full_reg;
  assign rd_ok = rd_en && !empty_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(rd_ok);
    level_next  = level_reg + C_LEVEL_W'(wr_ok) - C_LEVEL_W'(rd_ok);
  end

  always_ff @(posedge aclk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      full_reg   <= (level_next == LEVEL_FULL);
      empty_reg  <= (level_next == '0);
      // Next head comes from the array unless it is being written this cycle.
      if (wr_ok && (wr_ptr_reg == rd_ptr_next)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/func_hdl_stream_shell.sv
// Joins N input streams into a non-stallable compute core and buffers its
// results in a credit-protected FIFO with word counting, tlast and done.
module func_hdl_stream_shell
  import func_hdl_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 512,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_FIFO_DEPTH   = 16,
  parameter int C_COUNT_WIDTH  = 32
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   ctrl_start,
  input  logic [C_COUNT_WIDTH-1:0]               ctrl_num_words,
  output logic                                   ctrl_busy,
  output logic                                   ctrl_done,
  input  logic [C_NUM_CHANNELS-1:0]              s_tvalid,
  output logic [C_NUM_CHANNELS-1:0]              s_tready,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] s_tdata,
  output logic                                   core_ivalid,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] core_idata,
  input  logic                                   core_ovalid,
  input  logic [C_DATA_WIDTH-1:0]                core_odata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [C_DATA_WIDTH-1:0]                m_tdata,
  output logic                                   m_tlast,
  output logic                                   err_core
);

  localparam int DW       = C_DATA_WIDTH;
  localparam int CW       = C_COUNT_WIDTH;
  localparam int CREDIT_W = credit_width(C_FIFO_DEPTH);
  localparam logic [CW-1:0]       CNT_ONE     = CW'(1);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(C_FIFO_DEPTH);

  generate
    if (!is_pow2(C_FIFO_DEPTH) || (C_FIFO_DEPTH < 2)) begin : g_bad_depth
      $error("func_hdl_stream_shell: C_FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((C_NUM_CHANNELS < 1) || (C_NUM_CHANNELS > 8)) begin : g_bad_channels
      $error("func_hdl_stream_shell: C_NUM_CHANNELS must be within 1..8");
    end
  endgenerate

  state_t                state_reg;
  logic [CW-1:0]         num_reg;
  logic [CW-1:0]         issued_reg;
  logic [CW-1:0]         issued_next;
  logic [CW-1:0]         out_count_reg;
  logic [CW-1:0]         out_count_next;
  logic [CREDIT_W-1:0]   credits_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic                  issue;
  logic                  out_hs;
  logic                  last_word;
  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DW-1:0]         fifo_rd_data;

  // A credit stands for one FIFO slot, so a word is only issued once its
  // result is guaranteed room regardless of core latency.
  assign issue = (state_reg == RUN) && (&s_tvalid) &&
                 (credits_reg != '0) && (issued_reg < num_reg);

  assign issued_next    = issued_reg + CNT_ONE;
  assign out_count_next = out_count_reg + CNT_ONE;
  assign last_word      = (out_count_reg == (num_reg - CNT_ONE));

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_chan
      assign s_tready[gi]            = issue;
      assign core_idata[gi*DW +: DW] = issue ? s_tdata[gi*DW +: DW] : '0;
    end
  endgenerate

  assign core_ivalid = issue;

  assign fifo_wr = core_ovalid && (state_reg != IDLE);
  assign out_hs  = m_tvalid && m_tready;

  func_hdl_sync_fifo #(
    .C_DATA_WIDTH (DW),
    .C_DEPTH      (C_FIFO_DEPTH),
    .C_LEVEL_W    (CREDIT_W)
  ) u_out_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (fifo_wr),
    .wr_data (core_odata),
    .rd_en   (m_tready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_rd_data;
  assign m_tlast  = m_tvalid && last_word;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg     <= IDLE;
      num_reg       <= '0;
      issued_reg    <= '0;
      out_count_reg <= '0;
      credits_reg   <= CREDIT_FULL;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // The core cannot be stalled, so an unplaceable result is lost and flagged.
      if (core_ovalid && (fifo_full || (state_reg == IDLE))) begin
        err_reg <= 1'b1;
      end

      if (issue && !out_hs) begin
        credits_reg <= credits_reg - CREDIT_ONE;
      end else if (!issue && out_hs) begin
        credits_reg <= credits_reg + CREDIT_ONE;
      end

      if (out_hs) begin
        out_count_reg <= out_count_next;
      end

      case (state_reg)
        IDLE: begin
          if (ctrl_start) begin
            if (ctrl_num_words == '0) begin
              done_reg <= 1'b1;
            end else begin
              num_reg       <= ctrl_num_words;
              issued_reg    <= '0;
              out_count_reg <= '0;
              busy_reg      <= 1'b1;
              state_reg     <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issued_reg <= issued_next;
            if (issued_next == num_reg) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_hs && last_word) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ctrl_busy = busy_reg;
  assign ctrl_done = done_reg;
  assign err_core  = err_reg;

endmodule

// File: tb/tb_func_hdl_stream_shell.sv
// Directed scenarios with random payloads; a latency-programmable core model
// and a word-level reference of expected results drive every comparison.
module tb_func_hdl_stream_shell;

  localparam int DW    = 16;
  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic            aclk = 1'b0;
  logic            areset = 1'b0;
  logic            ctrl_start = 1'b0;
  logic [CW-1:0]   ctrl_num_words = '0;
  logic            ctrl_busy;
  logic            ctrl_done;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic            core_ivalid;
  logic [N*DW-1:0] core_idata;
  logic            core_ovalid = 1'b0;
  logic [DW-1:0]   core_odata = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic            err_core;

  always #5 aclk = ~aclk;

  func_hdl_stream_shell #(
    .C_DATA_WIDTH   (DW),
    .C_NUM_CHANNELS (N),
    .C_FIFO_DEPTH   (DEPTH),
    .C_COUNT_WIDTH  (CW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .ctrl_start     (ctrl_start),
    .ctrl_num_words (ctrl_num_words),
    .ctrl_busy      (ctrl_busy),
    .ctrl_done      (ctrl_done),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .core_ivalid    (core_ivalid),
    .core_idata     (core_idata),
    .core_ovalid    (core_ovalid),
    .core_odata     (core_odata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tlast        (m_tlast),
    .err_core       (err_core)
  );

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int lat = 3;
  int run_num = 0;
  int start_cyc = 0;
  int ch1_from = 0;
  int mrdy_from = 0;
  int n_issue, n_out, n_done;
  int first_issue, last_issue, last_hs, done_cyc;
  bit busy_seen, mvalid_seen;
  bit start_pend = 1'b0;
  logic [CW-1:0] start_num = '0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  bit force_ov = 1'b0;
  logic [DW-1:0] force_d = '0;

  logic [DW-1:0] w0[$];
  logic [DW-1:0] w1[$];
  logic [DW-1:0] exp_q[$];
  logic          sched_v [64];
  logic [DW-1:0] sched_d [64];

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a ^ {b[7:0], b[15:8]}) + 16'h1357;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setup_run(input int num, input int latency, input int c1_delay, input int mrdy_low);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    w0.delete();
    w1.delete();
    exp_q.delete();
    for (int k = 0; k < num; k++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      w0.push_back(a);
      w1.push_back(b);
      exp_q.push_back(core_fn(a, b));
    end
    lat = latency;
    run_num = num;
    n_issue = 0; n_out = 0; n_done = 0;
    first_issue = -1; last_issue = -1; last_hs = -1; done_cyc = -1;
    busy_seen = 1'b0; mvalid_seen = 1'b0;
    start_cyc = cyc;
    start_pend = 1'b1;
    start_num = CW'(num);
    ch1_from = cyc + c1_delay;
    mrdy_from = cyc + mrdy_low;
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step();
    int slot;
    bit hs;
    logic [DW-1:0] e;
    @(negedge aclk);
    slot = cyc % 64;
    core_ovalid = sched_v[slot] | force_ov;
    core_odata = sched_v[slot] ? sched_d[slot] : force_d;
    sched_v[slot] = 1'b0;
    ctrl_start = start_pend;
    ctrl_num_words = start_num;
    start_pend = 1'b0;
    s_tvalid[0] = (w0.size() > 0);
    s_tdata[DW-1:0] = (w0.size() > 0) ? w0[0] : '0;
    s_tvalid[1] = (w1.size() > 0) && (cyc >= ch1_from);
    s_tdata[2*DW-1:DW] = (w1.size() > 0) ? w1[0] : '0;
    m_tready = (cyc >= mrdy_from);
    #1;
    if (ctrl_busy) busy_seen = 1'b1;
    if (m_tvalid) mvalid_seen = 1'b1;
    hs = m_tvalid && m_tready;
    if (s_tready != '0) check("join_all_or_none", 64'(s_tready), 64'(2'b11));
    if (core_ivalid) begin
      if (first_issue < 0) first_issue = cyc;
      last_issue = cyc;
      if ((w0.size() == 0) || (w1.size() == 0) || (cyc < ch1_from)) begin
        check("issue_without_valid", 64'(1), 64'(0));
      end else begin
        check("issue_pairing", 64'(core_idata), 64'({w1[0], w0[0]}));
        check("in_flight_bound", 64'((n_issue + 1 - n_out - int'(hs)) <= DEPTH), 64'(1));
        sched_v[(cyc + lat) % 64] = 1'b1;
        sched_d[(cyc + lat) % 64] = core_fn(w0[0], w1[0]);
        void'(w0.pop_front());
        void'(w1.pop_front());
      end
      n_issue++;
    end
    if (prev_stall) begin
      check("hold_tvalid", 64'(m_tvalid), 64'(1));
      check("hold_tdata", 64'(m_tdata), 64'(prev_data));
      check("hold_tlast", 64'(m_tlast), 64'(prev_last));
    end
    if (m_tvalid) check("tlast", 64'(m_tlast), 64'(n_out == run_num - 1));
    else check("tlast_without_valid", 64'(m_tlast), 64'(0));
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(m_tdata), 64'(e));
      end
      n_out++;
      if (n_out == run_num) last_hs = cyc;
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
    if (ctrl_done) begin
      n_done++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic run_until_done(input int budget, input int probe_cyc, input int probe_n);
    int k;
    k = 0;
    while ((n_done == 0) && (k < budget)) begin
      step();
      if (cyc - 1 == probe_cyc) check("probe_issues", 64'(n_issue), 64'(probe_n));
      k++;
    end
    if (n_done == 0) check("run_timeout", 64'(0), 64'(1));
    step();
    step();
    check("done_count", 64'(n_done), 64'(1));
    check("words_out", 64'(n_out), 64'(run_num));
    check("ref_drained", 64'(exp_q.size()), 64'(0));
    check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
    check("busy_after_done", 64'(ctrl_busy), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(ctrl_busy), 64'(0));
    check({tag, "_done"}, 64'(ctrl_done), 64'(0));
    check({tag, "_tready"}, 64'(s_tready), 64'(0));
    check({tag, "_ivalid"}, 64'(core_ivalid), 64'(0));
    check({tag, "_idata"}, 64'(core_idata), 64'(0));
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
    check({tag, "_tlast"}, 64'(m_tlast), 64'(0));
    check({tag, "_err"}, 64'(err_core), 64'(0));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) begin
      sched_v[i] = 1'b0;
      sched_d[i] = '0;
    end
    #1 areset = 1'b1;
    #1;
    check_outputs_zero("reset");
    check("reset_tdata", 64'(m_tdata), 64'(0));
    repeat (2) @(negedge aclk);
    #1 areset = 1'b0;

    // 1: both channels always valid, latency 3, sink always ready
    setup_run(4, 3, 0, 0);
    run_until_done(60, -1, 0);
    check("t1_first_issue", 64'(first_issue), 64'(start_cyc + 1));
    check("t1_last_issue", 64'(last_issue), 64'(start_cyc + 4));
    check("t1_busy_seen", 64'(busy_seen), 64'(1));
    $display("[TB] test1 done: issues=%0d outs=%0d", n_issue, n_out);

    // 2: channel 1 lags channel 0 by five cycles
    setup_run(8, 3, 5, 0);
    run_until_done(80, -1, 0);
    check("t2_first_issue", 64'(first_issue), 64'(start_cyc + 5));
    $display("[TB] test2 done: issues=%0d outs=%0d", n_issue, n_out);

    // 3: sink blocked for 20 cycles, credits must cap issues at the FIFO depth
    setup_run(10, 6, 0, 21);
    run_until_done(200, start_cyc + 20, DEPTH);
    check("t3_err", 64'(err_core), 64'(0));
    $display("[TB] test3 done: issues=%0d outs=%0d", n_issue, n_out);

    // 4: zero-length run
    setup_run(0, 3, 0, 0);
    w0.push_back(DW'($urandom));
    w1.push_back(DW'($urandom));
    step();
    step();
    check("t4_done_next", 64'(done_cyc), 64'(start_cyc + 1));
    repeat (3) step();
    check("t4_no_issue", 64'(n_issue), 64'(0));
    check("t4_busy_never", 64'(busy_seen), 64'(0));
    check("t4_single_done", 64'(n_done), 64'(1));
    w0.delete();
    w1.delete();
    $display("[TB] test4 done: done_pulses=%0d", n_done);

    // 5: reset after three issues; late results must flag err_core
    setup_run(8, 6, 0, 0);
    k = 0;
    while ((n_issue < 3) && (k < 40)) begin
      step();
      k++;
    end
    check("t5_reach_three", 64'(n_issue), 64'(3));
    @(posedge aclk);
    #1 areset = 1'b1;
    #1;
    check_outputs_zero("t5_reset");
    w0.delete();
    w1.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    run_num = 0;
    step();
    step();
    areset = 1'b0;
    mvalid_seen = 1'b0;
    repeat (10) step();
    check("t5_late_err", 64'(err_core), 64'(1));
    check("t5_no_tvalid", 64'(mvalid_seen), 64'(0));
    setup_run(2, 3, 0, 0);
    run_until_done(60, -1, 0);
    check("t5_err_sticky", 64'(err_core), 64'(1));
    $display("[TB] test5 done: post-reset outs=%0d", n_out);

    // 6: core result while idle
    @(negedge aclk);
    #1 areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    check("t6_err_cleared", 64'(err_core), 64'(0));
    force_d = DW'($urandom);
    force_ov = 1'b1;
    step();
    force_ov = 1'b0;
    mvalid_seen = 1'b0;
    repeat (4) step();
    check("t6_idle_err", 64'(err_core), 64'(1));
    check("t6_no_tvalid", 64'(mvalid_seen), 64'(0));
    $display("[TB] test6 done: err_core=%0b", err_core);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
